gate_bist_ctrl: RTL

Self-test sequencer for a 2-input combinational gate such as `nand_gate`. On a start pulse it sweeps all four input vectors into the gate under test (GUT), waits a programmable settle time, and samples the gate output. It compares each sample against a parameterised truth table and reports pass/fail, a per-vector error mask and a failure count. It sits beside the GUT and owns the GUT's `A`/`B` inputs; the gate itself is unchanged.

---
 rtl/gate_bist_pkg.sv | 20 ++
 rtl/gate_bist_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned NumVec = 4;

    // Expected gate output indexed by {B,A}
    localparam logic [3:0] TtNand = 4'b0111;
    localparam logic [3:0] TtAnd  = 4'b1000;
    localparam logic [3:0] TtOr   = 4'b1110;
    localparam logic [3:0] TtNor  = 4'b0001;
    localparam logic [3:0] TtXor  = 4'b0110;

endpackage

// File: rtl/gate_bist_ctrl.sv
// Sweeps all four {B,A} vectors into a 2-input gate, waits SETTLE cycles per vector,
// samples C and accumulates a per-vector error mask and failure count.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  TRUTH  = TtNand
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       C,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [3:0] err_mask
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("gate_bist_ctrl: SETTLE must be in 1..15");
    end

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] fail_q, fail_d;
    logic [3:0] err_q, err_d;
    logic [1:0] ab_q, ab_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWait;
                    vec_d   = 2'd0;
                    cnt_d   = CntLoad;
                    fail_d  = 3'd0;
                    err_d   = 4'd0;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                if (C != TRUTH[vec_q]) begin
                    err_d[vec_q] = 1'b1;
                    fail_d       = fail_q + 3'd1;
                end
                if (vec_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = CntLoad;
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered gate inputs follow the next vector, parked at 0 outside a run
        ab_d = (state_d == StWait || state_d == StCheck) ? vec_d : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            fail_q  <= 3'd0;
            err_q   <= 4'd0;
            ab_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            ab_q    <= ab_d;
        end
    end

    assign A          = ab_q[0];
    assign B          = ab_q[1];
    assign busy       = (state_q == StWait) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign pass       = done && (fail_q == 3'd0);
    assign fail_count = fail_q;
    assign err_mask   = err_q;

endmodule
